// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 8-way round-robin grant encoder.
// Combinational definitions only; no latency or flow control here.
package arb_pkg;

  localparam int NREQ = 8;
  localparam int IDXW = 3;
  localparam int unsigned HOLD_MAX_DEF = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick8.sv
// Rotate-priority encoder: first set request after ptr, wrapping so ptr itself is checked last.
// Purely combinational, zero latency, no backpressure.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  // Scan from the farthest offset down so the nearest set bit after ptr wins.
  always_comb begin
    idx = ptr;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[IDXW'(32'(ptr) + k)]) begin
        idx = IDXW'(32'(ptr) + k);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_arb_enc8.sv
// Round-robin arbiter driving a 3-to-8 decoder select; 1-cycle req-to-grant, idle gap between grants,
// holder keeps the grant until done or request drop. ARB_TIMEOUT_EN bounds tenure to HOLD_MAX cycles.
module rr_arb_enc8
  import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEF
)
`endif
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_vld,
  output logic            busy,
  output logic            timeout
);

  state_e          state_q;
  logic [IDXW-1:0] ptr_q;
  logic [IDXW-1:0] gnt_idx_q;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;
  logic            release_c;

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign release_c = done | ~req[gnt_idx_q];

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       timeout_q;

  assign cnt_d = cnt_q + 8'd1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '1;
      gnt_idx_q <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            state_q   <= ST_GRANT;
            gnt_idx_q <= pick_idx;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
          end
        end
        ST_GRANT: begin
          // A normal release outranks the tenure limit, so timeout only fires on a forced release.
          if (release_c) begin
            state_q <= ST_IDLE;
            ptr_q   <= gnt_idx_q;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            state_q   <= ST_IDLE;
            ptr_q     <= gnt_idx_q;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
`endif
        end
      endcase
    end
  end

  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = (state_q == ST_GRANT);
  assign busy    = (state_q == ST_GRANT);
`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arb_enc8.sv
// Scoreboard bench for rr_arb_enc8: stimulus pushes model expectations, a monitor pops and compares.
module tb_rr_arb_enc8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  rr_arb_enc8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] idx;
    logic       vld;
    logic       bsy;
    logic       to;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: who holds the grant, who was served last, how long the holder has held it.
  bit m_granted;
  int m_holder;
  int m_last;
  int m_tenure;
  bit m_to;
  localparam int TB_HOLD = 16;

  function automatic void model_reset();
    m_granted = 0;
    m_holder  = 0;
    m_last    = 7;
    m_tenure  = 0;
    m_to      = 0;
  endfunction

  function automatic void model_step(input logic [7:0] r, input logic d);
    bit found;
    m_to = 0;
    if (!m_granted) begin
      if (r != 8'h00) begin
        found = 0;
        for (int k = 1; k <= 8; k++) begin
          int c;
          c = (m_last + k) % 8;
          if (!found && r[c]) begin
            m_holder = c;
            found    = 1;
          end
        end
        m_granted = 1;
        m_tenure  = 1;
      end
    end else begin
      if (d || !r[m_holder]) begin
        m_granted = 0;
        m_last    = m_holder;
      end
`ifdef ARB_TIMEOUT_EN
      else if (m_tenure == TB_HOLD) begin
        m_granted = 0;
        m_last    = m_holder;
        m_to      = 1;
      end else begin
        m_tenure = m_tenure + 1;
      end
`endif
    end
  endfunction

  function automatic void compare(input string name, input logic [5:0] act, input logic [5:0] req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_err++;
      $display("FAIL %s: got vld/busy/idx/to=%b required %b", name, act, req_v);
    end
  endfunction

  // Called at a falling edge: drive inputs, record expected post-edge outputs, move to next falling edge.
  task automatic step(input logic [7:0] r, input logic d);
    exp_t e;
    req  = r;
    done = d;
    model_step(r, d);
    e.idx = 3'(m_holder);
    e.vld = m_granted;
    e.bsy = m_granted;
    e.to  = m_to;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare("cycle", {gnt_vld, busy, gnt_idx, timeout}, {e.vld, e.bsy, e.idx, e.to});
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] r;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare("reset_state", {gnt_vld, busy, gnt_idx, timeout}, 6'b00_000_0);
    rst_n = 1'b1;

    // Single requester grant and release.
    step(8'h01, 0); step(8'h01, 0); step(8'h01, 1); step(8'h00, 0);
    // Rotation through 1, 2, 7 and wrap back to 1.
    step(8'h86, 0); step(8'h86, 1); step(8'h86, 0); step(8'h86, 1);
    step(8'h86, 0); step(8'h86, 1); step(8'h86, 0); step(8'h86, 1); step(8'h00, 0);
    // New requests during a grant are ignored; release by dropping the held request.
    step(8'h20, 0); step(8'h24, 0); step(8'h24, 0); step(8'h04, 0);
    step(8'h04, 0); step(8'h04, 1); step(8'h00, 0);
    // done while idle has no effect.
    step(8'h00, 1); step(8'h00, 1); step(8'h00, 0);
    // Long hold of one requester.
    for (int i = 0; i < 40; i++) step(8'h08, 0);
    step(8'h08, 1); step(8'h00, 0);
    // done and request drop together count once.
    step(8'h40, 0); step(8'h40, 0); step(8'h00, 1); step(8'h00, 0);
    // Self-regrant after idle gap.
    for (int i = 0; i < 6; i++) step(8'h10, (i % 2) == 1);

    // Asynchronous reset mid-grant.
    step(8'hF0, 0); step(8'hF0, 0);
    #2 rst_n = 1'b0;
    #1 compare("async_reset", {gnt_vld, busy, gnt_idx, timeout}, 6'b00_000_0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(8'hFF, 0); step(8'hFF, 1); step(8'hFF, 0); step(8'hFF, 1);

    // Random traffic, with sparse and dense request mixes.
    for (int i = 0; i < 3000; i++) begin
      r = 8'($urandom);
      if ((i / 500) % 2 == 0) r = r & 8'($urandom) & 8'($urandom);
      step(r, $urandom_range(0, 3) == 0);
    end
    step(8'h00, 0);
    step(8'h00, 0);
    @(negedge clk);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arb_enc8.md
Name: rr_arb_enc8

Overview:
8-requester round-robin arbiter that produces a binary grant index plus valid flag. Sits directly upstream of the 3-to-8 decoder. gnt_idx drives the decoder select input. The decoder's one-hot output gates the granted requester's resource.

Parameters:
NREQ, 8, number of requesters; fixed at 8 to match the 3-bit decoder select.
IDXW, 3, width of the grant index (log2 NREQ).
HOLD_MAX, 16, maximum grant tenure in cycles; used only when ARB_TIMEOUT_EN is defined; legal range 2..255.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  8  request vector, bit i = requester i
done  input  1  release strobe from the current grant holder, sampled in GRANT only
gnt_idx  output  3  binary index of the granted requester (feeds decoder select)
gnt_vld  output  1  grant valid; gnt_idx is meaningful only while high
busy  output  1  high while the FSM is in GRANT (equals gnt_vld)
timeout  output  1  one-cycle pulse on forced release; tied 0 without ARB_TIMEOUT_EN

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: gnt_idx=3'd0, gnt_vld=0, busy=0, timeout=0, state=IDLE, last-grant pointer ptr=3'd7 (first search starts at requester 0).
- All outputs are registered. No combinational path exists from req or done to any output.
- FSM states: IDLE, GRANT.
- IDLE with req!=0: search bits ptr+1, ptr+2, ... mod 8 and pick the first set bit. Next cycle: state=GRANT, gnt_vld=1, gnt_idx=winner. Latency is 1 cycle from req sampled to gnt_vld.
- IDLE with req==0: stay; outputs unchanged except gnt_vld=0.
- GRANT: gnt_idx is held stable. Release condition is done=1, or req[gnt_idx]=0.
- On release: next cycle state=IDLE, gnt_vld=0, ptr=gnt_idx. gnt_idx keeps its last value while invalid.
- Mandatory one-cycle idle gap between consecutive grants. No back-to-back regrant in the release cycle.
- Requests arriving or changing during GRANT have no effect until IDLE.
- done in IDLE is ignored.
- Single requester with the same bit held continuously: it is regranted after each idle gap (pointer wrap allows self-selection last).
- Pointer wrap: ptr=7 searches 0..7; ptr=3 searches 4,5,6,7,0,1,2,3.
- done and req[gnt_idx] drop in the same cycle: counts as a single release.
- Reset asserted mid-GRANT: outputs return to reset values immediately (asynchronous); ptr=7.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit tenure counter clears on entry to GRANT and increments each GRANT cycle.
  - When count reaches HOLD_MAX-1 without release, a forced release occurs: next cycle gnt_vld=0, ptr=gnt_idx, timeout=1 for exactly one cycle.
  - A normal release in the same cycle takes priority and timeout stays 0.
  - Counter reset value is 0.
- Not defined: no counter logic; timeout is driven constant 0; grant tenure is unbounded.

Decomposition:
- Shared package arb_pkg:
  - state encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1
  - NREQ/IDXW constants
  - HOLD_MAX default
- Sub-module rr_pick8: purely combinational rotate-priority encoder.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: idx[2:0], any.
  - Instantiated once inside rr_arb_enc8.

Test Plan:
- Reset then req=8'b0000_0001 -> one cycle later gnt_vld=1, gnt_idx=0. Assert done for 1 cycle -> gnt_vld=0 next cycle, ptr=0.
- Pointer at 0, req=8'b1000_0110 -> gnt_idx=1. Release, keep req -> gnt_idx=2. Release -> gnt_idx=7. Release -> gnt_idx=1 (wrap).
- In GRANT with gnt_idx=5, raise req[2], keep req[5] -> gnt_idx stays 5 and gnt_vld stays 1. Drop req[5] with done=0 -> release. After the idle gap, gnt_idx=2.
- Assert rst_n=0 asynchronously mid-GRANT -> gnt_vld=0 and gnt_idx=0 before the next clock edge. After release of reset with req=8'hFF -> gnt_idx=0.
- Assert done while in IDLE with req=0 -> no state change, gnt_vld remains 0, timeout 0.
- ARB_TIMEOUT_EN defined, HOLD_MAX=4, req[3] held, done=0 -> gnt_vld high for exactly 4 cycles. Then gnt_vld=0 and timeout=1 for 1 cycle. Regrant to 3 follows after the idle gap.
